// File: rtl/div_if.sv
// div_if: request/result bundle between the execute stage and the divider
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  modport master (output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, input result_o, ready_o);
  modport slave (input signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, output result_o, ready_o);
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-bit radix-2 restoring divider returning {remainder, quotient}
module div_unit (
  input logic clk,
  input logic rst,
  div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
  state_t      state_q, state_d;
  logic [64:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sign_quo_q, sign_quo_d;
  logic        sign_rem_q, sign_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic [31:0] a_mag, b_mag, quo, rem;
  logic [32:0] diff;
  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  // operand magnitudes, trial subtraction and sign correction of the final result
  always_comb begin
    a_mag = (bus.signed_div_i && bus.opdata1_i[31]) ? ~bus.opdata1_i + 32'd1 : bus.opdata1_i;
    b_mag = (bus.signed_div_i && bus.opdata2_i[31]) ? ~bus.opdata2_i + 32'd1 : bus.opdata2_i;
    diff  = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
    quo   = sign_quo_q ? ~dividend_q[31:0] + 32'd1 : dividend_q[31:0];
    rem   = sign_rem_q ? ~dividend_q[64:33] + 32'd1 : dividend_q[64:33];
  end
  // next-state and datapath updates; annul wins over every other transition
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      IDLE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) state_d = BYZERO;
          else begin
            state_d    = ON;
            dividend_d = {32'b0, a_mag, 1'b0};
            divisor_d  = b_mag;
            cnt_d      = '0;
            sign_quo_d = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            sign_rem_d = bus.signed_div_i & bus.opdata1_i[31];
          end
        end
      end
      BYZERO: begin
        if (bus.annul_i) state_d = IDLE;
        else begin
          result_d = '0;
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
      ON: begin
        if (bus.annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b0;
        end else if (cnt_q != 6'd32) begin
          dividend_d = diff[32] ? {dividend_q[63:0], 1'b0} : {diff[31:0], dividend_q[31:0], 1'b1};
          cnt_d      = cnt_q + 6'd1;
        end else begin
          result_d = {rem, quo};
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
      END: begin
        if (bus.annul_i || !bus.start_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and working registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random scoreboard bench for div_unit
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  div_if bus ();
  div_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sbv, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    sa = $signed(a);
    sbv = $signed(b);
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int lat, input logic chg);
    int n;
    logic [63:0] e;
    bus.signed_div_i = s;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i = 1'b1;
    sb.push_back(exp);
    tick;
    if (chg) begin
      bus.opdata1_i = ~a;
      bus.opdata2_i = b + 32'd5;
      bus.signed_div_i = ~s;
    end
    n = 0;
    while (!bus.ready_o && n < 100) begin
      tick;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    e = sb.pop_front();
    chk({tag, " result"}, bus.result_o, e);
    tick;
    chk({tag, " hold"}, {bus.result_o[62:0], bus.ready_o}, {e[62:0], 1'b1});
    bus.start_i = 1'b0;
    tick;
    chk({tag, " rel_ready"}, 64'(bus.ready_o), 64'd0);
    chk({tag, " rel_result"}, bus.result_o, 64'd0);
  endtask
  initial begin
    int seen;
    logic [31:0] a, b;
    logic s;
    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick;
    tick;
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    rst = 1'b0;
    tick;
    run("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0);
    run("s-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);
    run("s7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33, 1'b0);
    run("uffff_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33, 1'b0);
    run("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 1'b0);
    run("u_div0", 1'b0, 32'd1234, 32'd0, 64'd0, 1, 1'b0);
    run("s_div0", 1'b1, 32'h80000001, 32'd0, 64'd0, 1, 1'b0);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i = 1'b1;
    tick;
    repeat (9) tick;
    bus.annul_i = 1'b1;
    seen = 0;
    repeat (40) begin
      tick;
      if (bus.ready_o) seen++;
    end
    chk("annul_ready", 64'(seen), 64'd0);
    chk("annul_result", bus.result_o, 64'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    tick;
    run("u9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33, 1'b0);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i = 1'b1;
    tick;
    repeat (20) tick;
    rst = 1'b1;
    bus.start_i = 1'b0;
    tick;
    rst = 1'b0;
    chk("midrst_ready", 64'(bus.ready_o), 64'd0);
    chk("midrst_result", bus.result_o, 64'd0);
    repeat (40) tick;
    chk("midrst_quiet", 64'(bus.ready_o), 64'd0);
    run("after_rst", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, 1'b0);
    run("opchg", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 1'b1);
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i == 7) b = 32'd0;
      s = i[0];
      run("rand", s, a, b, model(s, a, b), (b == 32'd0) ? 1 : 33, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider that serves the execute stage's DIV/DIVU requests. The execute stage issues a request and holds it while it stalls the pipeline. This block performs radix-2 restoring division over 32 iteration cycles and returns `{remainder, quotient}` with a ready flag. The execute stage forwards that result to HI/LO, and the block is released once the request drops. The block also accepts an annul so a request killed by a flush never produces a result.

## Interface
Parameters: none (datapath fixed at 32 bits).

Clock and reset: one clock; reset is synchronous and active-high.

- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `signed_div_i` in 1: 1 = signed (DIV), 0 = unsigned (DIVU). Sampled at start.
- `opdata1_i` in 32: dividend. Sampled at start.
- `opdata2_i` in 32: divisor. Sampled at start.
- `start_i` in 1: request. The requester holds it high until it sees `ready_o`, then drops it.
- `annul_i` in 1: cancel any request in flight.
- `result_o` out 64: `{remainder[31:0], quotient[31:0]}`, routed as {HI, LO}. Registered.
- `ready_o` out 1: `result_o` is valid. Registered.

## Operation
- States: IDLE, BYZERO, ON, END.
- Working registers:
  - `dividend` is 65 bits.
  - `divisor` is 32 bits and holds the magnitude of the divisor.
  - `cnt` is 6 bits.
  - `sign_q` and `sign_r` are captured sign flags.
- IDLE:
  - If `start_i=1` and `annul_i=0` and `opdata2_i=0`, go to BYZERO.
  - If `start_i=1` and `annul_i=0` and the divisor is non-zero, go to ON and load:
    - `dividend = {32'b0, |opdata1_i|, 1'b0}`
    - `divisor = |opdata2_i|`
    - `cnt = 0`
    - `sign_q = signed & (a[31]^b[31])`
    - `sign_r = signed & a[31]`
  - Magnitude: if `signed_div_i` and bit31 is set, the operand is two's-complemented (`~x+1`); otherwise it is used as is.
  - Otherwise stay in IDLE with `ready_o=0` and `result_o=0`.
- BYZERO:
  - If `annul_i`, go to IDLE.
  - Otherwise set `result_o=0`, `ready_o=1`, and go to END.
- ON:
  - If `annul_i`, go to IDLE, clear `cnt`, keep `ready_o=0`.
  - While `cnt != 32`, each cycle compute the 33-bit `diff = {1'b0, dividend[63:32]} - {1'b0, divisor}`:
    - If `diff[32]=1` (negative): `dividend <= {dividend[63:0], 1'b0}`.
    - Otherwise: `dividend <= {diff[31:0], dividend[31:0], 1'b1}`.
    - In both cases `cnt <= cnt+1`.
  - When `cnt = 32`:
    - Quotient is `dividend[31:0]`; remainder is `dividend[64:33]`.
    - Negate the quotient if `sign_q`; negate the remainder if `sign_r`.
    - Load `result_o` with the corrected values, set `ready_o=1`, and go to END.
- END:
  - Hold `result_o` and `ready_o=1` while `start_i=1`.
  - When `start_i=0`, go to IDLE, clear `ready_o` and `result_o`.
  - `annul_i` in END also returns to IDLE and clears both outputs.
- Operand changes after the start cycle are ignored.
- Dropping `start_i` while in ON or BYZERO has no effect. Only `annul_i` cancels.
- Arithmetic:
  - Quotient is truncated toward zero.
  - The remainder carries the sign of the dividend.
  - Signed `0x80000000 / 0xFFFFFFFF` gives quotient `0x80000000` and remainder 0. The wrap is silent and raises no flag.
  - Divide by zero gives result 0 in both signed and unsigned modes; no exception is raised.

## Timing
- Reset: `rst=1` at an edge forces IDLE, `result_o=0`, `ready_o=0`, `cnt=0`, `dividend=0`. This holds from any state, including mid-ON.
- Normal latency: `start_i` sampled at edge E loads state ON. Iterations run at edges E+1..E+32. Finalisation runs at edge E+33, so `ready_o` and `result_o` are high from E+33.
- Divide-by-zero latency: BYZERO at E, then `ready_o=1` from edge E+1.
- Release: `ready_o` falls at the first edge at which `start_i=0` is sampled in END. A new request can be accepted at the following edge (IDLE).
- Annul has priority over every other transition in all states. It takes effect at the edge where it is sampled, and `ready_o` is never asserted for an annulled request.
- If `annul_i=1` and `start_i=1` arrive together in IDLE, the request is ignored.

## Test plan
- Unsigned 100 / 7, start held: `ready_o` rises exactly 33 edges after start with `result_o=64'h00000002_0000000E`. After `start_i` drops, `ready_o=0` and `result_o=0` at the next edge.
- Signed -7 / 2: `result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}`. Signed 7 / -2 gives `{32'h00000001, 32'hFFFFFFFD}`. Unsigned `0xFFFFFFFF / 1` gives `{0, 32'hFFFFFFFF}`.
- Signed `0x80000000 / 0xFFFFFFFF`: result `{0, 32'h80000000}`. Divide by zero (either mode): `ready_o` at E+1 with result 0.
- Annul at the 10th ON cycle: state returns to IDLE, and `ready_o` stays 0 for 40 cycles even with `start_i` held high. A fresh 9 / 3 request then completes with `{0, 3}` after 33 edges.
- `rst` pulse during ON iteration 20: all outputs 0 the next cycle. A subsequent request executes normally.
- Operands changed on the cycle after start: the result reflects the values sampled at start.
